// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums each group of NUM_TERMS unsigned 8-bit products into an ACC_W-bit
//   result and presents it on a valid/ready output. This is the MAC tail
//   behind the 4x4 multiplier.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   product is valid this cycle
//   in_ready   block accepts a product this cycle
//   product    unsigned 8-bit product
//   clear      synchronous abort of the current group (below rst only)
//   out_valid  acc_out holds a completed group sum
//   out_ready  downstream accepts acc_out
//   acc_out    completed group sum, unsigned
//   overflow   the group sum exceeded ACC_W bits
//
// Build option
//   PRODUCT_ACC_SATURATE_EN  defined: on overflow the accumulator clamps to
//                            all-ones for the rest of the group.
//                            undefined (default): the sum wraps modulo 2^ACC_W.
//                            Overflow is flagged in both cases.
module product_accumulator #(
  parameter int ACC_W     = 16,
  parameter int NUM_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grp_ovf_q, grp_ovf_d;   // sticky carry within the open group
  logic             ovf_q, ovf_d;           // flag reported with acc_out

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_next;
  logic             carry;
  logic             beat;

  // in_ready is gated by rst so no beat can be accepted while reset is held.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_out_q;
  assign overflow  = ovf_q;
  assign beat      = in_valid && in_ready;

  // One extra bit so the carry out of the accumulator is visible.
  assign sum_wide = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, product};
  assign carry    = sum_wide[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once clamped, stay clamped until the group closes.
  assign acc_next = (carry || grp_ovf_q) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign acc_next = sum_wide[ACC_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    cnt_d     = cnt_q;
    grp_ovf_d = grp_ovf_q;
    ovf_d     = ovf_q;

    if (clear) begin
      // Any beat in the same cycle is dropped; a pending result is discarded.
      state_d   = ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      grp_ovf_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            if (cnt_q == LAST_CNT) begin
              acc_out_d = acc_next;
              ovf_d     = grp_ovf_q | carry;
              acc_d     = '0;
              cnt_d     = '0;
              grp_ovf_d = 1'b0;
              state_d   = DONE;
            end else begin
              acc_d     = acc_next;
              cnt_d     = cnt_q + CNT_W'(1);
              grp_ovf_d = grp_ovf_q | carry;
            end
          end
        end
        DONE: begin
          // No bypass: the next group starts the cycle after the handshake.
          if (out_ready) begin
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      acc_out_q <= '0;
      cnt_q     <= '0;
      grp_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      cnt_q     <= cnt_d;
      grp_ovf_q <= grp_ovf_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: ACC_W=16, NUM_TERMS=4
  logic        rst, in_valid, in_ready, clear, out_valid, out_ready, overflow;
  logic [7:0]  product;
  logic [15:0] acc_out;

  // Narrow DUT for the overflow case: ACC_W=10, NUM_TERMS=8
  logic        in_valid_b, in_ready_b, clear_b, out_valid_b, out_ready_b, overflow_b;
  logic [7:0]  product_b;
  logic [9:0]  acc_out_b;

  product_accumulator #(.ACC_W(16), .NUM_TERMS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .overflow(overflow)
  );

  product_accumulator #(.ACC_W(10), .NUM_TERMS(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .product(product_b), .clear(clear_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .acc_out(acc_out_b), .overflow(overflow_b)
  );

`ifdef PRODUCT_ACC_SATURATE_EN
  localparam int EXP5 = 1023;
`else
  localparam int EXP5 = 776;   // 1800 mod 1024
`endif

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_results = 0;
  logic [16:0] exp_q[$];       // {overflow, acc_out}
  logic [16:0] mon_e;
  bit          rand_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Step to just after the next rising edge; optionally randomise out_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one product and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] p, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    in_valid = 1'b1;
    product  = p;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_timeout: got in_ready=0 for %0d cycles expected 1", t);
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: pops one expected value per result handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL result_unexpected: got acc_out=%0d expected no result", acc_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_acc_out", int'(acc_out), int'(mon_e[15:0]));
        check("result_overflow", int'(overflow), int'(mon_e[16]));
      end
      $display("result %0d: acc_out=%0d overflow=%0d", n_results, acc_out, overflow);
      n_results++;
    end
  end

  initial begin
    int sum;
    int w;
    logic [7:0] p;

    rst = 1'b1; in_valid = 1'b0; product = '0; clear = 1'b0; out_ready = 1'b0;
    in_valid_b = 1'b0; product_b = '0; clear_b = 1'b0; out_ready_b = 1'b0;

    // 1. Reset
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_acc_out", int'(acc_out), 0);
      check("rst_overflow", int'(overflow), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    tick();

    // 2. Four back-to-back beats of 225
    exp_q.push_back({1'b0, 16'd900});
    repeat (4) send(8'd225, 1'b0);
    @(negedge clk);
    check("t2_out_valid", int'(out_valid), 1);
    check("t2_acc_out", int'(acc_out), 900);
    check("t2_overflow", int'(overflow), 0);

    // 3. Backpressure with in_valid held high
    in_valid = 1'b1;
    product  = 8'd7;
    repeat (5) begin
      @(negedge clk);
      check("t3_in_ready", int'(in_ready), 0);
      check("t3_acc_out", int'(acc_out), 900);
      check("t3_out_valid", int'(out_valid), 1);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();                       // handshake edge
    @(negedge clk);
    check("t3_in_ready_after", int'(in_ready), 1);
    check("t3_out_valid_after", int'(out_valid), 0);
    tick();

    // 4. Clear mid-group discards the partial sum and the concurrent beat
    exp_q.push_back({1'b0, 16'd10});
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    clear = 1'b1; in_valid = 1'b1; product = 8'd99;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    repeat (3) tick();
    check("t4_drained", exp_q.size(), 0);

    // 5. ACC_W=10, NUM_TERMS=8: eight beats of 225
    in_valid_b = 1'b1;
    product_b  = 8'd225;
    repeat (8) begin
      @(negedge clk);
      check("t5_in_ready", int'(in_ready_b), 1);
      tick();
    end
    in_valid_b = 1'b0;
    @(negedge clk);
    check("t5_out_valid", int'(out_valid_b), 1);
    check("t5_acc_out", int'(acc_out_b), EXP5);
    check("t5_overflow", int'(overflow_b), 1);
    tick();
    out_ready_b = 1'b1;
    tick();                       // handshake edge
    @(negedge clk);
    check("t5_out_valid_after", int'(out_valid_b), 0);
    check("t5_overflow_after", int'(overflow_b), 0);
    tick();
    out_ready_b = 1'b0;

    // 6. Random gaps and stalls, 1000 groups
    rand_mode = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        p = 8'($urandom_range(0, 255));
        sum += int'(p);
        send(p, 1'b1);
      end
      exp_q.push_back({1'b0, 16'(sum)});
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    repeat (2) tick();
    check("t6_drained", exp_q.size(), 0);
    check("result_count", n_results, 1002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
